load_store_fsm: RTL
===================

Name: load_store_fsm

Overview:
- Single-outstanding data-memory sequencer sitting between the reservation-station side and the data cache port.
- Arbitrates between load read requests from the load reservation station and committed-store write requests from the head of the store buffer.
- Drives the dmem request, waits for dmem_resp, and returns completion:
  - for loads: load_rs_dmem_ready, load_rs_dmem_idx_executing and load data;
  - for stores: store_buffer_pop.
- Suppresses completion of loads killed by a flush.

Parameters:
LOAD_RS_DEPTH, 3, log2 of load RS entries; width of load index.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
move_flush  in  1  pipeline flush; kills in-flight load completion
dmem_r_rqst  in  1  load RS requests a read this cycle
load_rs_dmem_idx_rqst  in  LOAD_RS_DEPTH  requesting load RS entry
arbiter_load_rs_addr  in  32  load byte address
arbiter_load_rs_rmask  in  4  load byte mask
store_buffer_rqst  in  1  store buffer head valid, ready to write
store_buffer_full  in  1  store buffer full
store_buffer_head_addr  in  32  head store address
store_buffer_head_wmask  in  4  head store byte mask
store_buffer_head_wdata  in  32  head store data
store_buffer_pop  out  1  head store written; pop one entry
load_rs_dmem_ready  out  1  load completes this cycle
load_rs_dmem_idx_executing  out  LOAD_RS_DEPTH  completing load RS entry
load_rdata  out  32  read data for the completing load
dmem_addr  out  32  cache address, word aligned ({addr[31:2],2'b00})
dmem_rmask  out  4  read byte mask
dmem_wmask  out  4  write byte mask
dmem_wdata  out  32  write data
dmem_resp  in  1  cache response, one-cycle pulse
dmem_rdata  in  32  cache read data, valid with dmem_resp

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE.
  - All dmem_* outputs 0.
  - Latched index 0.
  - All completion outputs 0.
- States: IDLE, LOAD_WAIT, LOAD_DRAIN, STORE_WAIT.
- IDLE arbitration:
  - If store_buffer_rqst && (store_buffer_full || !dmem_r_rqst), choose the store.
  - Else if dmem_r_rqst && !move_flush, choose the load.
  - Else stay in IDLE.
  - A load request in a move_flush cycle is ignored.
  - Store arbitration ignores move_flush, since stores are committed.
- Load issue (IDLE, load chosen), registered at the next edge:
  - dmem_addr = aligned arbiter_load_rs_addr; dmem_rmask = arbiter_load_rs_rmask; dmem_wmask = 0.
  - Latch idx = load_rs_dmem_idx_rqst.
  - Next state LOAD_WAIT.
- Store issue (IDLE, store chosen), registered at the next edge:
  - dmem_addr = aligned head addr; dmem_wmask = head wmask; dmem_wdata = head wdata; dmem_rmask = 0.
  - Next state STORE_WAIT.
- Request hold: dmem_addr/rmask/wmask/wdata are held stable from the issue edge through the dmem_resp cycle. The masks are cleared at the edge ending the dmem_resp cycle.
- LOAD_WAIT:
  - On move_flush without dmem_resp, go to LOAD_DRAIN. Request stays held.
  - On dmem_resp:
    - load_rs_dmem_ready = !move_flush, combinational in that same cycle.
    - load_rs_dmem_idx_executing = latched idx.
    - load_rdata = dmem_rdata pass-through.
    - Next state IDLE.
- LOAD_DRAIN:
  - Wait for dmem_resp.
  - Never assert load_rs_dmem_ready.
  - On dmem_resp, go to IDLE.
- STORE_WAIT:
  - On dmem_resp, assert store_buffer_pop combinationally for one cycle, then go to IDLE.
  - move_flush has no effect in this state.
- Idle outputs: load_rs_dmem_ready=0, store_buffer_pop=0, load_rdata=0 except in the qualifying dmem_resp cycle.
- Throughput:
  - Exactly one outstanding dmem transaction at a time.
  - The state returns to IDLE at the edge ending the resp cycle, so the earliest next issue decision is the cycle after resp. Minimum 1 idle cycle between transactions.
- dmem_resp in IDLE (spurious) is ignored. It produces no completion.
- rst mid-transaction: return to IDLE immediately. The outstanding response is discarded.

Test Plan:
- Load then resp:
  - Stimulus: dmem_r_rqst=1, idx=5, addr=0x1000_0006, rmask=4'b1100 in cycle 0.
  - Required: dmem_addr=0x1000_0004, rmask=4'b1100 from cycle 1.
  - Stimulus: dmem_resp with rdata=0xDEADBEEF in cycle 3.
  - Required: load_rs_dmem_ready=1, idx=5, load_rdata=0xDEADBEEF in cycle 3; rmask=0 in cycle 4.
- Store: store_buffer_rqst=1, addr=0x2000_0000, wmask=4'b0001, wdata=0x0000_00AB, no load request -> wmask issued next cycle; store_buffer_pop=1 only in the resp cycle; load_rs_dmem_ready stays 0.
- Arbitration:
  - Load and store requested together with store_buffer_full=0 -> load issued first.
  - Same with store_buffer_full=1 -> store issued first, then the load is issued after the store resp.
- Flush mid-load:
  - Stimulus: issue load idx=2, move_flush in cycle 2, dmem_resp in cycle 5.
  - Required: state LOAD_DRAIN; load_rs_dmem_ready=0 in cycle 5; rmask held until cycle 5; IDLE in cycle 6.
- Flush coincident with resp or request:
  - move_flush and dmem_resp in the same LOAD_WAIT cycle -> no ready, back to IDLE.
  - dmem_r_rqst together with move_flush in IDLE -> no issue.
- Reset mid-store: rst during STORE_WAIT -> next cycle all dmem masks 0, state IDLE, no store_buffer_pop on a later dmem_resp.

Source files
------------

// File: rtl/load_store_fsm.sv
// load_store_fsm
//   Single-outstanding data-memory sequencer between the load reservation
//   station / store buffer and the data cache port. Arbitrates one request at
//   a time, holds the dmem request stable until dmem_resp, then returns the
//   completion (load ready/index/data, or store buffer pop).
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   move_flush                  pipeline flush; kills in-flight load completion
//   dmem_r_rqst                 load RS read request
//   load_rs_dmem_idx_rqst       requesting load RS entry
//   arbiter_load_rs_addr/rmask  load byte address / byte mask
//   store_buffer_rqst/full      store buffer head valid / buffer full
//   store_buffer_head_*         head store address / byte mask / data
//   store_buffer_pop            head store written this cycle
//   load_rs_dmem_ready          load completes this cycle
//   load_rs_dmem_idx_executing  completing load RS entry
//   load_rdata                  read data of the completing load
//   dmem_addr/rmask/wmask/wdata cache request (address word aligned)
//   dmem_resp, dmem_rdata       cache response pulse and read data
module load_store_fsm #(
  parameter int LOAD_RS_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     move_flush,
  input  logic                     dmem_r_rqst,
  input  logic [LOAD_RS_DEPTH-1:0] load_rs_dmem_idx_rqst,
  input  logic [31:0]              arbiter_load_rs_addr,
  input  logic [3:0]               arbiter_load_rs_rmask,
  input  logic                     store_buffer_rqst,
  input  logic                     store_buffer_full,
  input  logic [31:0]              store_buffer_head_addr,
  input  logic [3:0]               store_buffer_head_wmask,
  input  logic [31:0]              store_buffer_head_wdata,
  output logic                     store_buffer_pop,
  output logic                     load_rs_dmem_ready,
  output logic [LOAD_RS_DEPTH-1:0] load_rs_dmem_idx_executing,
  output logic [31:0]              load_rdata,
  output logic [31:0]              dmem_addr,
  output logic [3:0]               dmem_rmask,
  output logic [3:0]               dmem_wmask,
  output logic [31:0]              dmem_wdata,
  input  logic                     dmem_resp,
  input  logic [31:0]              dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD_WAIT,
    LOAD_DRAIN,
    STORE_WAIT
  } state_t;

  state_t                   state, state_nxt;
  logic [LOAD_RS_DEPTH-1:0] idx_q, idx_nxt;
  logic [31:0]              addr_nxt, wdata_nxt;
  logic [3:0]               rmask_nxt, wmask_nxt;
  logic                     pick_store, pick_load;

  // Byte offsets are dropped: the cache is addressed by word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{arbiter_load_rs_addr[1:0], store_buffer_head_addr[1:0]};

  // Committed stores win when the buffer is full or no load competes; a load
  // seen during a flush belongs to a squashed path and is not issued.
  assign pick_store = store_buffer_rqst && (store_buffer_full || !dmem_r_rqst);
  assign pick_load  = !pick_store && dmem_r_rqst && !move_flush;

  always_comb begin
    state_nxt                  = state;
    idx_nxt                    = idx_q;
    addr_nxt                   = dmem_addr;
    rmask_nxt                  = dmem_rmask;
    wmask_nxt                  = dmem_wmask;
    wdata_nxt                  = dmem_wdata;
    store_buffer_pop           = 1'b0;
    load_rs_dmem_ready         = 1'b0;
    load_rs_dmem_idx_executing = '0;
    load_rdata                 = '0;

    unique case (state)
      IDLE: begin
        if (pick_store) begin
          state_nxt = STORE_WAIT;
          addr_nxt  = {store_buffer_head_addr[31:2], 2'b00};
          wmask_nxt = store_buffer_head_wmask;
          wdata_nxt = store_buffer_head_wdata;
          rmask_nxt = '0;
        end else if (pick_load) begin
          state_nxt = LOAD_WAIT;
          addr_nxt  = {arbiter_load_rs_addr[31:2], 2'b00};
          rmask_nxt = arbiter_load_rs_rmask;
          wmask_nxt = '0;
          idx_nxt   = load_rs_dmem_idx_rqst;
        end
      end
      LOAD_WAIT: begin
        if (dmem_resp) begin
          // A flush arriving with the response still kills the completion.
          if (!move_flush) begin
            load_rs_dmem_ready         = 1'b1;
            load_rs_dmem_idx_executing = idx_q;
            load_rdata                 = dmem_rdata;
          end
          state_nxt = IDLE;
          rmask_nxt = '0;
          wmask_nxt = '0;
        end else if (move_flush) begin
          state_nxt = LOAD_DRAIN;
        end
      end
      LOAD_DRAIN: begin
        if (dmem_resp) begin
          state_nxt = IDLE;
          rmask_nxt = '0;
          wmask_nxt = '0;
        end
      end
      STORE_WAIT: begin
        if (dmem_resp) begin
          store_buffer_pop = 1'b1;
          state_nxt        = IDLE;
          rmask_nxt        = '0;
          wmask_nxt        = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx_q      <= '0;
      dmem_addr  <= '0;
      dmem_rmask <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else begin
      state      <= state_nxt;
      idx_q      <= idx_nxt;
      dmem_addr  <= addr_nxt;
      dmem_rmask <= rmask_nxt;
      dmem_wmask <= wmask_nxt;
      dmem_wdata <= wdata_nxt;
    end
  end

endmodule
